imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sequences writes into the 256-word instruction memory at boot.
- Takes a byte stream from a host link (UART receiver or testbench) over a valid/ready handshake and packs bytes little-endian into 32-bit instructions.
- Writes each packed word to consecutive word addresses through the memory's write port.
- Holds the CPU core in reset while loading, then releases it so fetch begins at PC 0.

Parameters:
- DEPTH, 256, number of 32-bit instruction words in the memory.
- ADDR_W, 8, word-address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load session.
- len_words  input  ADDR_W+1  number of words to load; sampled only on the cycle start is accepted.
- rx_data  input  8  incoming program byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high.
- imem_we  output  1  instruction-memory write strobe.
- imem_waddr  output  ADDR_W  word address of the write (byte address = imem_waddr << 2).
- imem_wdata  output  32  instruction word to write.
- cpu_reset  output  1  held high to keep the core in reset.
- busy  output  1  a load session is in progress.
- done  output  1  the load completed; the core is running.
- err_len  output  1  the requested length was illegal.

Behaviour:
- States: IDLE, RECV, WRITE, DONE, ERR. Reset forces IDLE.
- Reset values: rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_reset=1, busy=0, done=0, err_len=0. The internal byte counter, word counter, latched length and assembly register all clear to 0.
- IDLE: cpu_reset=1. start is accepted in this state.
  - len_words==0 -> DONE. This runs the image already in memory.
  - 1 <= len_words <= DEPTH -> latch the length, clear the counters, go to RECV.
  - len_words > DEPTH -> ERR.
- RECV: rx_ready=1 and busy=1.
  - On each handshake, place the byte into the assembly register at bits [8*byte_cnt+7 : 8*byte_cnt], then increment byte_cnt (2 bits).
  - The handshake that carries the 4th byte (byte_cnt==3) moves the FSM to WRITE.
  - rx_valid low stalls indefinitely with no timeout.
  - Bytes presented while rx_ready=0 are not consumed.
- WRITE: exactly one cycle.
  - imem_we=1, imem_waddr=word_cnt, imem_wdata=assembled word, rx_ready=0, busy=1.
  - imem_we therefore rises on the cycle after the 4th-byte handshake.
  - Next: if word_cnt == len-1 -> DONE. Otherwise increment word_cnt, clear byte_cnt, return to RECV.
  - imem_we is high only in WRITE.
- Throughput: at most one word per 5 cycles (4 byte handshakes plus 1 write cycle).
- DONE: cpu_reset=0, done=1, busy=0, rx_ready=0. The state is held.
  - start in DONE re-enters the IDLE decision on the same edge: cpu_reset goes back to 1 and done to 0, i.e. a reload.
- ERR: err_len=1, cpu_reset=1, rx_ready=0.
  - start with a legal len_words leaves ERR exactly as from IDLE, and err_len clears.
- start during RECV or WRITE is ignored.
- Ordering and widths:
  - Words are written strictly in order 0..len-1 with no address wrap; len==DEPTH ends at address DEPTH-1.
  - word_cnt is ADDR_W bits wide and is compared against len-1 (ADDR_W+1 bits).
- Synchronous reset mid-load:
  - Returns to IDLE next edge and discards the partial word; no write is issued.
  - Words already written remain in memory.
  - cpu_reset=1.
- reset and start high on the same edge: reset wins.

Test Plan:
- Load 2 words: start with len_words=2, then bytes 13,01,50,00,93,01,C0,00 with rx_valid always high.
  - Expect imem_we at addr 0 with data 00500113, then at addr 1 with data 00C00193.
  - Expect exactly 2 write pulses and rx_ready low during each WRITE cycle.
  - Expect done=1 and cpu_reset=0 on the cycle after the second WRITE.
- Backpressure: same as the 2-word load, but rx_valid toggles randomly with gaps of up to 10 cycles.
  - Written data is identical; no byte is duplicated or dropped.
- Lengths:
  - len_words=0 -> DONE one cycle after start; no imem_we.
  - len_words=257 -> err_len=1, cpu_reset stays 1, rx_ready=0.
  - A following start with len=1 clears err_len and loads normally.
- Full depth: len_words=256 with word i = i.
  - 256 writes, last at addr 255 (FF), then DONE; no wrap.
- Mid-load reset: assert reset after 6 bytes of a 3-word load.
  - 1 write seen at addr 0; no further imem_we.
  - Outputs return to reset values.
  - A new start with len=1 writes addr 0 again.
- Reload and ignored start: start pulsed in DONE with len=1.
  - cpu_reset rises and done falls the next cycle, and a new word is written at addr 0.
  - start pulsed during RECV is ignored and word_cnt is unchanged.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: packs a little-endian host byte stream into 32-bit words,
// writes them to consecutive instruction-memory addresses, and holds the CPU
// core in reset until the image is complete.
module imem_boot_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err_len
);

  localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_WORD_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W-1:0] r_word_cnt;
  logic [ADDR_W:0]   r_len;
  logic [31:0]       r_asm;

  logic w_start_win;
  logic w_len_zero;
  logic w_len_legal;
  logic w_load;
  logic w_hs;
  logic w_last;

  // start is only honoured from the resting states; RECV/WRITE ignore it
  assign w_start_win = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERR));
  assign w_len_zero  = (len_words == '0);
  assign w_len_legal = !w_len_zero && (len_words <= LP_DEPTH);
  assign w_load      = w_start_win && w_len_legal;
  assign w_hs        = rx_valid && rx_ready;
  assign w_last      = ({1'b0, r_word_cnt} == (r_len - LP_LEN_ONE));

  // Write port and status are decoded from the registered state and datapath
  assign imem_waddr = r_word_cnt;
  assign imem_wdata = r_asm;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Byte packing, word counter and latched length
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_asm      <= '0;
    end else if (w_load) begin
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_len      <= len_words;
      r_asm      <= '0;
    end else if ((r_state == S_RECV) && w_hs) begin
      r_asm[8*r_byte_cnt +: 8] <= rx_data;
      r_byte_cnt               <= r_byte_cnt + 2'd1;
    end else if ((r_state == S_WRITE) && !w_last) begin
      r_word_cnt <= r_word_cnt + LP_WORD_ONE;
      r_byte_cnt <= '0;
    end
  end

  // Next-state decode and state-driven outputs
  always_comb begin
    w_next    = r_state;
    rx_ready  = 1'b0;
    imem_we   = 1'b0;
    cpu_reset = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    err_len   = 1'b0;

    // DONE and ERR reuse the IDLE length decision on the edge start arrives
    if (w_start_win) begin
      if (w_len_zero) begin
        w_next = S_DONE;
      end else if (w_len_legal) begin
        w_next = S_RECV;
      end else begin
        w_next = S_ERR;
      end
    end

    case (r_state)
      S_IDLE: begin
      end
      S_RECV: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (w_hs && (r_byte_cnt == 2'd3)) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        w_next  = w_last ? S_DONE : S_RECV;
      end
      S_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      S_ERR: begin
        err_len = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader with hand-computed expectations.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  len_words;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err_len;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          ready_in_write = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .DEPTH (256),
    .ADDR_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len_words (len_words),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err_len   (err_len)
  );

  // Record every write strobe seen on the memory port
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
      if (rx_ready) ready_in_write++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    ready_in_write = 0;
  endtask

  task automatic do_start(input logic [8:0] len);
    start     = 1'b1;
    len_words = len;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Present one byte after `gap` idle cycles; returns at the negedge after it was taken
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    rx_data  = 8'hEE;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: rx_ready=%b required 1 within 100 cycles", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int unsigned k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    len_words = 9'd2;
    repeat (2) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    checks++;
    if ({rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, err_len} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b we=%b a=%h d=%h cr=%b busy=%b done=%b err=%b required 0 0 00 0 1 0 0 0",
               rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, err_len);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins_over_start: busy=%b rx_ready=%b required 0 0", busy, rx_ready);
    end
  endtask

  task automatic test_load2();
    clear_log();
    do_start(9'd2);
    checks++;
    if (busy !== 1'b1 || rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL load2_recv: busy=%b rx_ready=%b cpu_reset=%b required 1 1 1", busy, rx_ready, cpu_reset);
    end
    send_word(32'h00500113, 0);
    send_word(32'h00C00193, 0);
    checks++;
    if (imem_we !== 1'b1 || imem_waddr !== 8'h01 || rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL load2_second_write: we=%b addr=%h rx_ready=%b required 1 01 0", imem_we, imem_waddr, rx_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL load2_done: done=%b cpu_reset=%b busy=%b required 1 0 0", done, cpu_reset, busy);
    end
    checks++;
    if (wr_addr.size() !== 2) begin
      failures++;
      $display("FAIL load2_write_count: got %0d required 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00500113 ||
          wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h00C00193) begin
        failures++;
        $display("FAIL load2_data: %h:%h %h:%h required 00:00500113 01:00C00193",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
    checks++;
    if (ready_in_write !== 0) begin
      failures++;
      $display("FAIL load2_ready_in_write: got %0d cycles required 0", ready_in_write);
    end
  endtask

  task automatic test_reload_backpressure();
    clear_log();
    do_start(9'd2);
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reload_from_done: cpu_reset=%b done=%b busy=%b required 1 0 1", cpu_reset, done, busy);
    end
    send_word(32'h00500113, 10);
    send_word(32'h00C00193, 10);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || wr_addr.size() !== 2) begin
      failures++;
      $display("FAIL bp_done: done=%b writes=%0d required 1 2", done, wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00500113 ||
          wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h00C00193) begin
        failures++;
        $display("FAIL bp_data: %h:%h %h:%h required 00:00500113 01:00C00193",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_lengths();
    clear_log();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_start(9'd0);
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0) begin
      failures++;
      $display("FAIL len0_done: done=%b cpu_reset=%b required 1 0", done, cpu_reset);
    end
    do_start(9'd257);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (err_len !== 1'b1 || cpu_reset !== 1'b1 || rx_ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL len257_err: err=%b cpu_reset=%b rx_ready=%b done=%b required 1 1 0 0",
               err_len, cpu_reset, rx_ready, done);
    end
    rx_valid = 1'b0;
    do_start(9'd1);
    checks++;
    if (err_len !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL err_recover: err=%b busy=%b required 0 1", err_len, busy);
    end
    send_word(32'hDEADBEEF, 0);
    @(negedge clk);
    checks++;
    if (wr_addr.size() !== 1 || done !== 1'b1) begin
      failures++;
      $display("FAIL err_then_load: writes=%0d done=%b required 1 1", wr_addr.size(), done);
    end else begin
      checks++;
      if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL err_then_load_data: %h:%h required 00:deadbeef", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_full_depth();
    int bad;
    clear_log();
    do_start(9'd256);
    for (int i = 0; i < 256; i++) begin
      send_word(32'(i), 0);
    end
    @(negedge clk);
    checks++;
    if (wr_addr.size() !== 256 || done !== 1'b1) begin
      failures++;
      $display("FAIL full_count: writes=%0d done=%b required 256 1", wr_addr.size(), done);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (wr_addr[i] !== i[7:0] || wr_data[i] !== 32'(i)) bad++;
      end
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL full_words: %0d mismatched words required 0", bad);
      end
      checks++;
      if (wr_addr[255] !== 8'hFF) begin
        failures++;
        $display("FAIL full_last_addr: got %h required ff", wr_addr[255]);
      end
    end
  endtask

  task automatic test_midload_reset();
    clear_log();
    do_start(9'd3);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, err_len} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_outputs: rdy=%b we=%b a=%h d=%h cr=%b busy=%b done=%b err=%b required 0 0 00 0 1 0 0 0",
               rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, err_len);
    end
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h11223344) begin
      failures++;
      $display("FAIL midreset_writes: writes=%0d required 1 at 00 data 11223344", wr_addr.size());
    end
    clear_log();
    do_start(9'd1);
    send_word(32'hCAFEF00D, 0);
    @(negedge clk);
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hCAFEF00D || done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reload: writes=%0d done=%b required 1 write 00:cafef00d done 1", wr_addr.size(), done);
    end
  endtask

  task automatic test_ignored_start();
    clear_log();
    do_start(9'd2);
    send_word(32'h01020304, 0);
    send_byte(8'h08, 0);
    do_start(9'd1);
    checks++;
    if (imem_waddr !== 8'h01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ignored_start_wordcnt: addr=%h busy=%b required 01 1", imem_waddr, busy);
    end
    send_byte(8'h07, 0);
    send_byte(8'h06, 0);
    send_byte(8'h05, 0);
    @(negedge clk);
    checks++;
    if (wr_addr.size() !== 2 || done !== 1'b1) begin
      failures++;
      $display("FAIL ignored_start_count: writes=%0d done=%b required 2 1", wr_addr.size(), done);
    end else begin
      checks++;
      if (wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h05060708) begin
        failures++;
        $display("FAIL ignored_start_data: %h:%h required 01:05060708", wr_addr[1], wr_data[1]);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    len_words = '0;
    rx_data   = '0;
    rx_valid  = 1'b0;
    @(negedge clk);
    test_reset();
    test_load2();
    test_reload_backpressure();
    test_lengths();
    test_full_depth();
    test_midload_reset();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
